// File: rtl/shift_register_5bit_right_pkg.sv
// Shared constants and helpers for the 5-bit right-shift register slice.
package shift_register_5bit_right_pkg;

  // Register width; fixed by the lab board's LED bank.
  localparam int unsigned SR_WIDTH = 5;

  // Per-edge operation selected by the control inputs.
  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_PRESET = 2'd1,
    OP_SHIFT  = 2'd2
  } sr_op_e;

  // Priority decode: clear dominates preset, which dominates shift.
  function automatic sr_op_e sr_decode(input logic clear, input logic enable_preset);
    if (clear)
      return OP_CLEAR;
    else if (enable_preset)
      return OP_PRESET;
    else
      return OP_SHIFT;
  endfunction

endpackage

// File: rtl/shift_register_5bit_right_dff_cell.sv
// One-bit D flip-flop with synchronous active-high clear and a
// complementary output held in its own flop.
module dff_cell (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q,
  output logic qn
);

  // True and complement flops update together so qn never lags q.
  always_ff @(posedge clk) begin
    if (clear) begin
      q  <= 1'b0;
      qn <= 1'b1;
    end else begin
      q  <= d;
      qn <= ~d;
    end
  end

endmodule

// File: rtl/shift_register_5bit_right.sv
// 5-bit synchronous right-shift register with parallel preset, serial
// input at bit 4 and complementary outputs. Bit 0 is shifted out and lost.
module shift_register_5bit_right
  import shift_register_5bit_right_pkg::*;
(
  input  logic                clockpulse,
  input  logic                clear,
  input  logic                serialInput,
  input  logic                enablePreset,
  input  logic [SR_WIDTH-1:0] preset,
  output logic [SR_WIDTH-1:0] out,
  output logic [SR_WIDTH-1:0] notout
);

  sr_op_e              op;
  logic [SR_WIDTH-1:0] shifted;
  logic [SR_WIDTH-1:0] d;

  // Next-state select per bit: clear, else preset, else shift toward bit 0.
  always_comb begin
    op      = sr_decode(clear, enablePreset);
    shifted = {serialInput, out[SR_WIDTH-1:1]};
    d       = shifted;
    unique case (op)
      OP_CLEAR:  d = '0;
      OP_PRESET: d = preset;
      OP_SHIFT:  d = shifted;
      default:   d = shifted;
    endcase
  end

  // Five storage cells; notout comes straight from their complement flops.
  dff_cell u_bit [SR_WIDTH-1:0] (
    .clk   (clockpulse),
    .clear (clear),
    .d     (d),
    .q     (out),
    .qn    (notout)
  );

endmodule

// File: tb/tb_shift_register_5bit_right.sv
// Bench for shift_register_5bit_right: directed scenarios followed by random
// traffic, all compared against an arithmetic model of the register.
module tb_shift_register_5bit_right;

  logic       clockpulse;
  logic       clear;
  logic       serialInput;
  logic       enablePreset;
  logic [4:0] preset;
  logic [4:0] out;
  logic [4:0] notout;

  int unsigned total;
  int unsigned bad;
  int          model;

  shift_register_5bit_right dut (
    .clockpulse   (clockpulse),
    .clear        (clear),
    .serialInput  (serialInput),
    .enablePreset (enablePreset),
    .preset       (preset),
    .out          (out),
    .notout       (notout)
  );

  initial clockpulse = 1'b0;
  always #5 clockpulse = ~clockpulse;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs for one rising edge, advance the model, then
  // compare both outputs on the following falling edge.
  task automatic step(input string tag, input logic c, input logic ep,
                      input logic [4:0] p, input logic s);
    clear        = c;
    enablePreset = ep;
    preset       = p;
    serialInput  = s;
    @(posedge clockpulse);
    if (c)
      model = 0;
    else if (ep)
      model = int'(p);
    else
      model = (model / 2) + (s ? 16 : 0);
    @(negedge clockpulse);
    check({tag, ".out"}, out, model[4:0]);
    check({tag, ".notout"}, notout, 5'(31 - model));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    model        = 0;
    clear        = 1'b0;
    enablePreset = 1'b0;
    preset       = '0;
    serialInput  = 1'b0;
    @(negedge clockpulse);

    step("reset", 1'b1, 1'b0, 5'b00000, 1'b0);
    check("reset.const", out, 5'b00000);

    step("preset", 1'b0, 1'b1, 5'b00011, 1'b0);
    check("preset.const", notout, 5'b11100);
    for (int unsigned i = 0; i < 15; i++)
      step("drain", 1'b0, 1'b0, 5'b11111, 1'b0);
    check("drain.const", out, 5'b00000);

    for (int unsigned i = 0; i < 5; i++)
      step("fill", 1'b0, 1'b0, 5'b00000, 1'b1);
    check("fill.const", out, 5'b11111);

    step("priority", 1'b1, 1'b1, 5'b10101, 1'b1);
    check("priority.const", out, 5'b00000);

    step("shift1", 1'b0, 1'b0, 5'b00000, 1'b1);
    step("shift2", 1'b0, 1'b0, 5'b00000, 1'b0);
    step("midpreset", 1'b0, 1'b1, 5'b10110, 1'b1);
    check("midpreset.const", out, 5'b10110);
    step("postpreset", 1'b0, 1'b0, 5'b00000, 1'b0);
    check("postpreset.const", out, 5'b01011);

    for (int unsigned i = 0; i < 300; i++)
      step("random", ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
           5'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
